// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: byte-serial fetch, PC ownership, branch redirect
//
// Purpose: owns the PC. Fetches each 32-bit instruction as four sequential byte reads and
// holds the assembled word for the IF/ID register until the stall controller lets it pass.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall_pcreg     stall code: 00 Pass, 01 Hold, 10 Bubb, 11 treated as Hold
//   redirect_valid  taken branch/jump from EX this cycle
//   redirect_pc     redirect target
//   mem_req         byte read request
//   mem_addr        byte address of the request (low ADDR_W bits)
//   mem_valid       request completed this cycle
//   mem_rdata       returned byte
//   stall_if        fetch not ready
//   inst_valid      inst/inst_pc hold a complete instruction
//   inst            assembled instruction, little-endian
//   inst_pc         PC of inst
`timescale 1ns/1ps
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stall_pcreg,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_rdata,
  output logic              stall_if,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [31:0] inst_buf;
  logic        flush;
  logic [31:0] tgt;
  logic [31:0] byte_addr;

  // Address depends only on registered pc/cnt, so it cannot move while a request
  // is outstanding (pc/cnt only change on mem_valid in S_REQ).
  assign byte_addr  = pc + {30'b0, cnt};
  assign mem_addr   = byte_addr[ADDR_W-1:0];
  assign mem_req    = (state == S_REQ);
  assign stall_if   = (state != S_DONE);
  // A redirect in S_DONE means the held instruction is on the wrong path.
  assign inst_valid = (state == S_DONE) && !redirect_valid;
  assign inst       = inst_buf;
  assign inst_pc    = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      flush    <= 1'b0;
      inst_buf <= 32'h0;
      tgt      <= 32'h0;
      state    <= S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (flush) begin
            // Waiting out a request that was already issued on the wrong path.
            if (redirect_valid) tgt <= redirect_pc;
            if (mem_valid) begin
              pc    <= redirect_valid ? redirect_pc : tgt;
              cnt   <= 2'd0;
              flush <= 1'b0;
            end
          end else if (redirect_valid) begin
            if (mem_valid) begin
              pc  <= redirect_pc;
              cnt <= 2'd0;
            end else begin
              flush <= 1'b1;
              tgt   <= redirect_pc;
            end
          end else if (mem_valid) begin
            case (cnt)
              2'd0:    inst_buf[7:0]   <= mem_rdata;
              2'd1:    inst_buf[15:8]  <= mem_rdata;
              2'd2:    inst_buf[23:16] <= mem_rdata;
              default: inst_buf[31:24] <= mem_rdata;
            endcase
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= S_DONE;
          end
        end
        default: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            cnt   <= 2'd0;
            state <= S_REQ;
          end else if (stall_pcreg == 2'b00) begin
            pc    <= pc + 32'd4;
            cnt   <= 2'd0;
            state <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_pcreg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_rdata;
  logic        stall_if;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_pass  = 0;
  int n_total = 0;
  int wait_n  = 0;
  int wcnt    = 0;

  logic [7:0] mem [0:1023];

  inst_fetch #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pcreg    (stall_pcreg),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .stall_if       (stall_if),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory: answers after wait_n idle cycles; shares rst with the DUT.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 8'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || mem_req !== 1'b1) begin
        mem_valid = 1'b0;
        wcnt = 0;
      end else if (wcnt >= wait_n) begin
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr[9:0]];
        wcnt = 0;
      end else begin
        mem_valid = 1'b0;
        wcnt++;
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic [1:0] st, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = 1'b0;
    stall_pcreg = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    #2;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    stall_pcreg = 2'b01;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
  endtask

  // Advances with Hold until inst_valid, bounded by limit cycles.
  task automatic wait_inst(input string name, input int limit);
    int n;
    n = 0;
    cyc(2'b01, 1'b0, 32'h0);
    while (inst_valid !== 1'b1 && n < limit) begin
      cyc(2'b01, 1'b0, 32'h0);
      n++;
    end
    chk({name, "_timeout"}, {31'b0, inst_valid}, 32'd1);
  endtask

  typedef struct {
    logic        chk;
    logic        rst;
    logic [1:0]  st;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        stl;
    logic        iv;
    logic        ci;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t v(input logic c, input logic r, input logic [1:0] st,
                             input logic rv, input logic [31:0] rpc, input logic req,
                             input logic [31:0] addr, input logic stl, input logic iv,
                             input logic ci, input logic [31:0] ins, input logic [31:0] pc);
    vec_t t;
    t.chk = c; t.rst = r; t.st = st; t.rv = rv; t.rpc = rpc; t.req = req;
    t.addr = addr; t.stl = stl; t.iv = iv; t.ci = ci; t.inst = ins; t.pc = pc;
    return t;
  endfunction

  vec_t tv [20];

  initial begin
    rst = 1'b1;
    stall_pcreg = 2'b00;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) + 8'(8'h37 * (i >> 8));
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2]  = 8'h50; mem[3]  = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h00; mem[6]  = 8'h10; mem[7]  = 8'h00;
    mem[8] = 8'h13; mem[9] = 8'h81; mem[10] = 8'h20; mem[11] = 8'h00;

    //          chk rst st     rv rpc        req addr    stl iv ci inst          pc
    tv[0]  = v(0, 1, 2'b00, 0, 32'h0,     0, 32'h0,  1,  0, 0, 32'h0,        32'h0);
    tv[1]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h0,  1,  0, 1, 32'h0,        32'h0);
    tv[2]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h1,  1,  0, 0, 32'h0,        32'h0);
    tv[3]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h2,  1,  0, 0, 32'h0,        32'h0);
    tv[4]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h3,  1,  0, 0, 32'h0,        32'h0);
    tv[5]  = v(1, 0, 2'b00, 0, 32'h0,     0, 32'h0,  0,  1, 1, 32'h00500013, 32'h0);
    tv[6]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h4,  1,  0, 0, 32'h0,        32'h4);
    tv[7]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h5,  1,  0, 0, 32'h0,        32'h4);
    tv[8]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h6,  1,  0, 0, 32'h0,        32'h4);
    tv[9]  = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h7,  1,  0, 0, 32'h0,        32'h4);
    tv[10] = v(1, 0, 2'b01, 0, 32'h0,     0, 32'h0,  0,  1, 1, 32'h00100093, 32'h4);
    tv[11] = v(1, 0, 2'b10, 0, 32'h0,     0, 32'h0,  0,  1, 1, 32'h00100093, 32'h4);
    tv[12] = v(1, 0, 2'b11, 0, 32'h0,     0, 32'h0,  0,  1, 1, 32'h00100093, 32'h4);
    tv[13] = v(1, 0, 2'b00, 0, 32'h0,     0, 32'h0,  0,  1, 1, 32'h00100093, 32'h4);
    tv[14] = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h8,  1,  0, 0, 32'h0,        32'h8);
    tv[15] = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h9,  1,  0, 0, 32'h0,        32'h8);
    tv[16] = v(1, 0, 2'b00, 0, 32'h0,     1, 32'ha,  1,  0, 0, 32'h0,        32'h8);
    tv[17] = v(1, 0, 2'b00, 0, 32'h0,     1, 32'hb,  1,  0, 0, 32'h0,        32'h8);
    tv[18] = v(1, 0, 2'b00, 1, 32'h40,    0, 32'h0,  0,  0, 1, 32'h00208113, 32'h8);
    tv[19] = v(1, 0, 2'b00, 0, 32'h0,     1, 32'h40, 1,  0, 0, 32'h0,        32'h40);

    wait_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      stall_pcreg = tv[i].st;
      redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc;
      #2;
      if (tv[i].chk) begin
        chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, tv[i].req});
        if (tv[i].req) chk($sformatf("v%0d_addr", i), mem_addr, tv[i].addr);
        chk($sformatf("v%0d_stall_if", i), {31'b0, stall_if}, {31'b0, tv[i].stl});
        chk($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tv[i].iv});
        if (tv[i].ci) chk($sformatf("v%0d_inst", i), inst, tv[i].inst);
        chk($sformatf("v%0d_inst_pc", i), inst_pc, tv[i].pc);
      end
    end

    // Two wait cycles per byte: each address held 3 cycles, inst_valid in cycle 12.
    reset_dut();
    wait_n = 2;
    for (int c = 0; c < 13; c++) begin
      cyc(2'b01, 1'b0, 32'h0);
      if (c < 12) begin
        chk($sformatf("w2_c%0d_stall", c), {31'b0, stall_if}, 32'd1);
        chk($sformatf("w2_c%0d_addr", c), mem_addr, 32'(c / 3));
      end else begin
        chk("w2_iv", {31'b0, inst_valid}, 32'd1);
        chk("w2_inst", inst, 32'h00500013);
      end
    end

    // Redirect while byte 2 is pending: address held, then restart at 0x100.
    reset_dut();
    wait_n = 2;
    for (int c = 0; c < 6; c++) cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b1, 32'h100);
    chk("rd_c6_addr", mem_addr, 32'h2);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rd_c7_addr", mem_addr, 32'h2);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rd_c8_addr", mem_addr, 32'h2);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rd_c9_addr", mem_addr, 32'h100);
    wait_inst("rd", 40);
    chk("rd_inst", inst, exp_word(32'h100));
    chk("rd_pc", inst_pc, 32'h100);

    // Two redirects during one pending byte: last one wins.
    reset_dut();
    for (int c = 0; c < 6; c++) cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b1, 32'h200);
    cyc(2'b01, 1'b1, 32'h300);
    chk("rd2_c7_addr", mem_addr, 32'h2);
    cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rd2_c9_addr", mem_addr, 32'h300);
    wait_inst("rd2", 40);
    chk("rd2_inst", inst, exp_word(32'h300));
    chk("rd2_pc", inst_pc, 32'h300);

    // Redirect arriving on the cycle the flushed request completes.
    reset_dut();
    for (int c = 0; c < 6; c++) cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b1, 32'h200);
    cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b1, 32'h280);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rd3_c9_addr", mem_addr, 32'h280);

    // Zero-wait redirect coincident with mem_valid: byte dropped, immediate restart.
    reset_dut();
    wait_n = 0;
    cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b1, 32'h80);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rdz_addr", mem_addr, 32'h80);
    wait_inst("rdz", 20);
    chk("rdz_inst", inst, exp_word(32'h80));
    chk("rdz_pc", inst_pc, 32'h80);

    // Reset mid-fetch at cnt=2.
    reset_dut();
    cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b0, 32'h0);
    cyc(2'b01, 1'b0, 32'h0);
    chk("rst_mid_pre_addr", mem_addr, 32'h2);
    reset_dut();
    cyc(2'b01, 1'b0, 32'h0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    chk("rst_mid_iv", {31'b0, inst_valid}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_if}, 32'd1);
    chk("rst_mid_inst", inst, 32'h0);
    wait_inst("rst_mid", 20);
    chk("rst_mid_word", inst, 32'h00500013);

    // PC wrap: redirect to 0xFFFFFFFC from S_DONE, fetch, Pass wraps to 0.
    cyc(2'b01, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_rv_iv", {31'b0, inst_valid}, 32'd0);
    cyc(2'b01, 1'b0, 32'h0);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    wait_inst("wrap", 20);
    chk("wrap_inst", inst, exp_word(32'hFFFF_FFFC));
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    cyc(2'b00, 1'b0, 32'h0);
    cyc(2'b01, 1'b0, 32'h0);
    chk("wrap_next_addr", mem_addr, 32'h0);
    chk("wrap_next_pc", inst_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the 5-stage RISC-V core. It owns the PC, reads each 32-bit instruction from the byte-wide memory port as four sequential byte requests, and presents the assembled instruction to the IF/ID register. It raises `stall_if` to the stall controller while no instruction is ready. It consumes the controller's `stall_pcreg` code and EX-stage branch redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: memory address width; `mem_addr` = low `ADDR_W` bits of the byte address.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `stall_pcreg` input 2: stall code from the stall controller. 2'b00 Pass, 2'b01 Hold, 2'b10 Bubb, 2'b11 is treated as Hold.
- `redirect_valid` input 1: taken branch/jump from EX this cycle.
- `redirect_pc` input 32: redirect target.
- `mem_req` output 1: byte read request.
- `mem_addr` output ADDR_W: byte address of the request.
- `mem_valid` input 1: request completed this cycle; `mem_rdata` is valid.
- `mem_rdata` input 8: returned byte.
- `stall_if` output 1: fetch not ready.
- `inst_valid` output 1: `inst`/`inst_pc` hold a complete instruction.
- `inst` output 32: assembled instruction, little-endian.
- `inst_pc` output 32: PC of `inst`.

## Operation
- Registers:
  - `pc[31:0]`
  - `cnt[1:0]`: byte index
  - `buf[31:0]`
  - state ∈ {S_REQ, S_DONE}
  - `flush` flag
  - `tgt[31:0]`: latched redirect target
- S_REQ:
  - `mem_req`=1, `mem_addr` = (pc + cnt)[ADDR_W-1:0]. No alignment requirement; the addition wraps mod 2^32.
  - On `mem_valid` with `flush`=0: `buf[8*cnt+7 -: 8]` ← `mem_rdata`, cnt ← cnt+1. When cnt was 3: state ← S_DONE, cnt ← 0.
- S_DONE:
  - `mem_req`=0; `inst_valid`=1 unless `redirect_valid`; `inst`=buf, `inst_pc`=pc.
  - Pass: pc ← pc+4 (wraps), state ← S_REQ, cnt ← 0.
  - Hold, Bubb or 2'b11: no change.
- `stall_if` = (state != S_DONE). `stall_pcreg` is ignored in S_REQ.
- Request rule: once `mem_req` is high, it and `mem_addr` stay stable until `mem_valid`. A request is never withdrawn except by `rst`.
- Redirect, which has priority over `stall_pcreg`:
  - In S_DONE: pc ← `redirect_pc`, cnt ← 0, state ← S_REQ.
  - In S_REQ with `mem_valid` the same cycle: byte discarded, pc ← `redirect_pc`, cnt ← 0, `flush` ← 0.
  - In S_REQ without `mem_valid`: `flush` ← 1, `tgt` ← `redirect_pc`. The outstanding request is held.
  - While `flush`=1: a further redirect overwrites `tgt`. On `mem_valid`: byte discarded, pc ← `tgt` (or `redirect_pc` if one is asserted that same cycle), cnt ← 0, `flush` ← 0.
- `rst` has priority over everything: pc ← `RESET_PC`, cnt ← 0, `flush` ← 0, buf ← 0, state ← S_REQ. Any outstanding memory request is abandoned; the memory controller shares `rst`.

## Timing
- Output values in the cycle after `rst`: `mem_req`=1, `mem_addr`=RESET_PC, `stall_if`=1, `inst_valid`=0, `inst`=0, `inst_pc`=RESET_PC.
- Zero-wait memory (`mem_valid` in the same cycle as `mem_req`):
  - Bytes are accepted in cycles 0–3.
  - `inst_valid`=1 and `stall_if`=0 in cycle 4.
  - A Pass in cycle 4 puts the next request in cycle 5. Throughput is one instruction per 5 cycles.
- Each extra wait cycle on a byte adds exactly one cycle of latency.
- Redirect in S_DONE: request at `redirect_pc` in the next cycle.
- Redirect with a pending request: the new fetch starts the cycle after the held request's `mem_valid`.
- `inst_valid` and `stall_if` are decoded from registered state. The only combinational input path to them is `redirect_valid` masking `inst_valid`.

## Test plan
- Reset, zero-wait memory returning bytes 13,00,50,00 at RESET_PC=0 -> `inst`=32'h0050_0013, `inst_pc`=0, `inst_valid` in cycle 4. Pass -> `mem_addr`=4 in cycle 5.
- Memory with 2 wait cycles per byte -> each address held 3 cycles, `inst_valid` in cycle 12, `stall_if`=1 throughout cycles 0–11.
- Hold for 3 cycles in S_DONE -> `inst`/`inst_pc` stable, `mem_req`=0, pc unchanged. Then Pass -> pc+4.
- Redirect to 32'h100 while byte 2 is pending with 3-cycle latency -> address held until `mem_valid`, byte discarded, next request at 32'h100, assembled instruction contains no stale bytes.
- Two redirects (32'h200, then 32'h300) during one pending byte -> fetch restarts at 32'h300.
- `rst` asserted mid-fetch at cnt=2 -> next cycle `mem_addr`=RESET_PC, cnt=0. Also: pc=32'hFFFF_FFFC with Pass -> wraps to 0.
